// File: rtl/pipe_pkg.sv
// Shared widths, vector types and helpers for the elastic pipeline chain.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned MAX_STAGES = 64;

  typedef logic [MAX_STAGES-1:0] stageVec_t;

  function automatic int unsigned popcount(input stageVec_t v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register slot: kill beats load, load beats hold.
module pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             kill,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  always_ff @(posedge clk) begin
    if (rst)       v_q <= 1'b0;
    else if (kill) v_q <= 1'b0;
    else if (ld)   v_q <= v_in;
  end

  // Payload carries no reset; it is only meaningful while v_q is set.
  always_ff @(posedge clk) begin
    if (ld) d_q <= d_in;
  end

endmodule

// File: rtl/pipe_chain.sv
// Parametrised elastic pipeline: STAGES slots with valid/ready, per-slot flush,
// global stall, registered occupancy and a saturating count of flushed items.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         stall,
  input  logic [STAGES-1:0]            flush,
  output logic [STAGES-1:0]            stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int unsigned OCC_W = $clog2(STAGES+1);
  localparam int unsigned SUM_W = CNT_W + OCC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vq;
  logic [STAGES-1:0] vIn;
  logic [STAGES-1:0] vNext;
  logic [WIDTH-1:0]  dq  [STAGES];
  logic [WIDTH-1:0]  dIn [STAGES];
  logic [OCC_W-1:0]  killed;
  logic [SUM_W-1:0]  cntSum;

  // Ready ripples from the output back to slot 0; walked downward so the
  // block never reads a bit it has not yet written.
  always_comb begin
    logic r;
    rdy         = '0;
    r           = out_ready;
    rdy[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      r                  = !stall && (!vq[STAGES-1-i] || r);
      rdy[STAGES-1-i]    = r;
    end
  end

  always_comb begin
    vIn    = '0;
    dIn    = '{default: '0};
    vNext  = '0;
    killed = '0;
    vIn[0] = in_valid;
    dIn[0] = in_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      vIn[k] = vq[k-1];
      dIn[k] = dq[k-1];
    end
    // A kill counts whatever the slot would otherwise have held after the edge.
    for (int unsigned k = 0; k < STAGES; k++) begin
      vNext[k] = flush[k] ? 1'b0 : (rdy[k] ? vIn[k] : vq[k]);
      if (flush[k] && (rdy[k] ? vIn[k] : vq[k])) killed = killed + OCC_W'(1);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    pipe_stage #(.WIDTH(WIDTH)) uStage (
      .clk  (clk),
      .rst  (rst),
      .ld   (rdy[k]),
      .kill (flush[k]),
      .v_in (vIn[k]),
      .d_in (dIn[k]),
      .v_q  (vq[k]),
      .d_q  (dq[k])
    );
  end

  assign cntSum = SUM_W'(flush_cnt) + SUM_W'(killed);

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      flush_cnt <= '0;
    end else begin
      occupancy <= OCC_W'(popcount(stageVec_t'(vNext)));
      flush_cnt <= (cntSum > SUM_W'(CNT_MAX)) ? CNT_MAX : cntSum[CNT_W-1:0];
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = vq[STAGES-1];
  assign out_data    = dq[STAGES-1];
  assign stage_valid = vq;

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: default instance plus a CNT_W=2 instance for saturation.
module tb_pipe_chain;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 4;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          stall;
  logic [S-1:0]  flush;
  logic [S-1:0]  stage_valid;
  logic [OW-1:0] occupancy;
  logic [15:0]   flush_cnt;

  logic          inReadyS;
  logic          outValidS;
  logic [W-1:0]  outDataS;
  logic [S-1:0]  stageValidS;
  logic [OW-1:0] occupancyS;
  logic [1:0]    flushCntS;

  int total = 0;
  int bad   = 0;
  int delivered = 0;
  logic [W-1:0] expQ [$];

  pipe_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall),
    .flush(flush), .stage_valid(stage_valid), .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  pipe_chain #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyS), .in_data(in_data),
    .out_valid(outValidS), .out_ready(out_ready), .out_data(outDataS), .stall(stall),
    .flush(flush), .stage_valid(stageValidS), .occupancy(occupancyS), .flush_cnt(flushCntS)
  );

  always #5 clk = ~clk;

  // Handshakes are judged mid-cycle, ahead of the edge at which they complete.
  always @(negedge clk) begin
    logic [W-1:0] expV;
    if (!rst) begin
      if (out_valid && out_ready && !stall) begin
        delivered++;
        total++;
        if (expQ.size() == 0) begin
          bad++; $display("FAIL out_unexpected got=%0h want=none", out_data);
        end else begin
          expV = expQ.pop_front();
          if (out_data !== expV) begin
            bad++; $display("FAIL out_data got=%0h want=%0h", out_data, expV);
          end
        end
      end
      if (in_valid && in_ready && !flush[0]) expQ.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    expQ.delete();
    delivered = 0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    total++; if (stage_valid !== 4'h0) begin bad++; $display("FAIL rst_sv got=%0h want=0", stage_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", flush_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ov got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ir got=%0b want=1", in_ready); end
  endtask

  task automatic test_stream();
    logic expOv;
    doReset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_valid = (cyc < 10);
      in_data  = W'(cyc + 1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ir c=%0d got=%0b want=1", cyc, in_ready); end
      tick();
      expOv = (cyc + 1 >= 4) && (cyc + 1 <= 13);
      total++; if (out_valid !== expOv) begin bad++; $display("FAIL stream_ov c=%0d got=%0b want=%0b", cyc + 1, out_valid, expOv); end
    end
    in_valid = 1'b0;
    total++; if (delivered !== 10) begin bad++; $display("FAIL stream_count got=%0d want=10", delivered); end
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL stream_left got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_fill_drain();
    int accepted;
    doReset();
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = W'(32'h11 + accepted);
      #1;
      total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL fill_ir i=%0d got=%0b want=%0b", i, in_ready, (i < 4)); end
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d want=4", occupancy); end
    total++; if (stage_valid !== 4'hF) begin bad++; $display("FAIL fill_sv got=%0h want=f", stage_valid); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (occupancy !== OW'(4 - k)) begin bad++; $display("FAIL drain_occ k=%0d got=%0d want=%0d", k, occupancy, 4 - k); end
    end
    total++; if (delivered !== 4) begin bad++; $display("FAIL drain_count got=%0d want=4", delivered); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_ov got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    doReset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 32'h0C; tick();
    in_data = 32'h0B; tick();
    in_data = 32'h0A; tick();
    in_valid = 1'b0; stall = 1'b1; flush = 4'b0011;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_stall_ir got=%0b want=0", in_ready); end
    tick();
    stall = 1'b0; flush = '0;
    void'(expQ.pop_back());
    void'(expQ.pop_back());
    total++; if (stage_valid !== 4'b0100) begin bad++; $display("FAIL flush_sv got=%0h want=4", stage_valid); end
    total++; if (flush_cnt !== 16'd2) begin bad++; $display("FAIL flush_cnt got=%0d want=2", flush_cnt); end
    tick(); tick(); tick();
    total++; if (delivered !== 1) begin bad++; $display("FAIL flush_deliv got=%0d want=1", delivered); end
    in_valid = 1'b1; in_data = 32'h0D; flush = 4'b0001;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL kill_in_ir got=%0b want=1", in_ready); end
    tick();
    in_valid = 1'b0; flush = '0;
    total++; if (stage_valid !== 4'h0) begin bad++; $display("FAIL kill_in_sv got=%0h want=0", stage_valid); end
    total++; if (flush_cnt !== 16'd3) begin bad++; $display("FAIL kill_in_cnt got=%0d want=3", flush_cnt); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0E;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (stage_valid !== 4'b1000) begin bad++; $display("FAIL kill_out_sv got=%0h want=8", stage_valid); end
    out_ready = 1'b1; flush = 4'b1000;
    tick();
    flush = '0;
    total++; if (delivered !== 2) begin bad++; $display("FAIL kill_out_deliv got=%0d want=2", delivered); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kill_out_ov got=%0b want=0", out_valid); end
    total++; if (flush_cnt !== 16'd3) begin bad++; $display("FAIL kill_out_cnt got=%0d want=3", flush_cnt); end
  endtask

  task automatic test_stall();
    doReset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(32'h21 + i);
      tick();
    end
    stall = 1'b1; in_data = 32'h25;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (stage_valid !== 4'hF) begin bad++; $display("FAIL stall_sv i=%0d got=%0h want=f", i, stage_valid); end
      total++; if (out_data !== 32'h21) begin bad++; $display("FAIL stall_od i=%0d got=%0h want=21", i, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ir i=%0d got=%0b want=0", i, in_ready); end
    end
    flush = 4'b0010;
    tick();
    flush = '0;
    expQ.delete(2);
    total++; if (stage_valid !== 4'b1101) begin bad++; $display("FAIL stall_flush_sv got=%0h want=d", stage_valid); end
    total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL stall_flush_cnt got=%0d want=1", flush_cnt); end
    total++; if (out_data !== 32'h21) begin bad++; $display("FAIL stall_flush_od got=%0h want=21", out_data); end
    stall = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++; if (delivered !== 3) begin bad++; $display("FAIL stall_deliv got=%0d want=3", delivered); end
  endtask

  task automatic test_saturate();
    logic [15:0] expCnt;
    logic [1:0]  expSat;
    doReset();
    out_ready = 1'b1; in_valid = 1'b1; flush = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      in_data = W'(32'h100 + i);
      tick();
      expCnt = 16'(i + 1);
      expSat = (i + 1 >= 3) ? 2'd3 : 2'(i + 1);
      total++; if (flush_cnt !== expCnt) begin bad++; $display("FAIL sat_main i=%0d got=%0d want=%0d", i, flush_cnt, expCnt); end
      total++; if (flushCntS !== expSat) begin bad++; $display("FAIL sat_small i=%0d got=%0d want=%0d", i, flushCntS, expSat); end
    end
    flush = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(32'h41 + i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL sat_fill_occ got=%0d want=4", occupancy); end
    total++; if (outDataS !== 32'h41) begin bad++; $display("FAIL sat_fill_od got=%0h want=41", outDataS); end
    stall = 1'b1; flush = 4'hF;
    tick();
    stall = 1'b0; flush = '0;
    expQ.delete();
    total++; if (flush_cnt !== 16'd9) begin bad++; $display("FAIL sat_multi_main got=%0d want=9", flush_cnt); end
    total++; if (flushCntS !== 2'd3) begin bad++; $display("FAIL sat_multi_small got=%0d want=3", flushCntS); end
    total++; if (stageValidS !== 4'h0) begin bad++; $display("FAIL sat_multi_sv got=%0h want=0", stageValidS); end
    total++; if (occupancyS !== 3'd0) begin bad++; $display("FAIL sat_multi_occ got=%0d want=0", occupancyS); end
    total++; if (outValidS !== 1'b0) begin bad++; $display("FAIL sat_multi_ov got=%0b want=0", outValidS); end
    #1;
    total++; if (inReadyS !== 1'b1) begin bad++; $display("FAIL sat_multi_ir got=%0b want=1", inReadyS); end
  endtask

  task automatic test_reset_midflight();
    doReset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h30; flush = 4'b0001;
    tick();
    flush = '0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(32'h31 + i);
      tick();
    end
    in_data = 32'h35;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL mid_occ_pre got=%0d want=4", occupancy); end
    total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL mid_cnt_pre got=%0d want=1", flush_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    expQ.delete();
    delivered = 0;
    total++; if (stage_valid !== 4'h0) begin bad++; $display("FAIL mid_sv got=%0h want=0", stage_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL mid_occ got=%0d want=0", occupancy); end
    total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", flush_cnt); end
    total++; if (flushCntS !== 2'd0) begin bad++; $display("FAIL mid_cnt_small got=%0d want=0", flushCntS); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ov i=%0d got=%0b want=0", i, out_valid); end
    end
    total++; if (delivered !== 0) begin bad++; $display("FAIL mid_deliv got=%0d want=0", delivered); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_stream();
    test_fill_drain();
    test_flush();
    test_stall();
    test_saturate();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
